fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the multi-cycle core's decoder.
- Issues 32-bit instruction reads to instruction memory over a req/ack handshake with variable latency.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents them downstream over valid/ready; a redirect from branch/jump resolution flushes the buffer and restarts fetch.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // The fetcher only requests with a guaranteed slot, so a push into a full FIFO is a bug.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues memory reads over req/ack, buffers {pc, inst} and handles redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                PCSIZE   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [PCSIZE-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req,
    output logic [PCSIZE-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [INST_W-1:0]      mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INST_W-1:0]      out_inst,
    output logic [PCSIZE-1:0]      out_pc,
    input  logic                   redirect,
    input  logic [PCSIZE-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = PCSIZE + INST_W;

    fetch_state_t      state_q, state_d;
    logic [PCSIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [PCSIZE-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              valid_q, valid_d;

    logic              push, pop, space;
    logic [CW-1:0]     count, occ_next;
    logic [PCSIZE-1:0] redir_pc;
    logic [FW-1:0]     head;
    logic              unused_redirect_lsbs;

    assign redir_pc             = {redirect_pc[PCSIZE-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A flush beats both the response push and the consumer pop.
    assign push     = (state_q == REQ) && mem_ack && !redirect;
    assign pop      = valid_q && out_ready && !redirect;
    assign occ_next = redirect ? '0 : count + CW'(push) - CW'(pop);
    assign space    = occ_next < CW'(DEPTH);

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({fetch_pc_q, mem_rdata}),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        valid_d    = (occ_next != '0);

        if (redirect) begin
            fetch_pc_d = redir_pc;
        end

        unique case (state_q)
            IDLE: begin
                if (space) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_d;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!redirect) begin
                        fetch_pc_d = fetch_pc_q + PCSIZE'(4);
                    end
                    // Ack with redirect: flush makes room, so go straight to the new PC.
                    if (space) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_d;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end else if (redirect) begin
                    // Outstanding handshake must complete; its data is thrown away.
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign out_valid  = valid_q;
    assign out_pc     = head[FW-1:INST_W];
    assign out_inst   = head[INST_W-1:0];
    assign fifo_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, scoreboard of expected {pc, inst}, immediate-assert checks.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [2:0]  fifo_count;

    fetch_unit #(
        .PCSIZE   (64),
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return NOP ^ (a[31:0] << 4) ^ a[63:32];
    endfunction

    assign mem_rdata = inst_of(mem_addr);

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_addr = '0;
    logic [63:0] drop_addr = '0;
    bit          drop_pending = 0;
    bit          auto_mem = 0;
    bit          prev_req = 0;
    int          lat = 0;
    int          age = 0;
    int          cyc_n = 0;
    int          n_acks = 0;
    int          n_pops = 0;
    int          req_seen = -1;
    int          val_seen = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs at the falling edge: inputs are stable for the coming rising edge.
    task automatic mon();
        exp_t e;
        prev_req = mem_req;
        if (mem_req === 1'b1 && req_seen < 0) req_seen = cyc_n;
        if (out_valid === 1'b1 && val_seen < 0) val_seen = cyc_n;
        if (mem_req === 1'b1 && mem_ack) begin
            n_acks++;
            chk("ack_addr", mem_addr, drop_pending ? drop_addr : exp_addr);
            if (drop_pending) begin
                drop_pending = 0;
            end else if (!redirect) begin
                sb.push_back('{pc: exp_addr, inst: inst_of(exp_addr)});
                exp_addr += 64'd4;
            end
        end
        if (out_valid === 1'b1 && out_ready && !redirect) begin
            n_pops++;
            if (sb.size() == 0) begin
                chk("out_unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", 64'(out_inst), 64'(e.inst));
            end
        end
        if (redirect) begin
            if (mem_req === 1'b1 && !mem_ack && !drop_pending) begin
                drop_pending = 1;
                drop_addr    = exp_addr;
            end
            sb.delete();
            exp_addr = {redirect_pc[63:2], 2'b00};
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
        if (auto_mem) begin
            if (mem_ack) age = 0;
            else if (prev_req) age++;
            mem_ack = (mem_req === 1'b1) && (age >= lat);
        end
    endtask

    task automatic ack1();
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        auto_mem  = 0;
        mem_ack   = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        age       = 0;
        cyc();
        cyc();
        sb.delete();
        exp_addr     = '0;
        drop_pending = 0;
        rst          = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8 && mem_req !== 1'b1; i++) cyc();
        chk("wait_mem_req", 64'(mem_req), 64'd1);
    endtask

    int pops0;

    initial begin
        // Reset values, applied asynchronously before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        cyc();

        // 1-cycle memory latency, consumer always ready
        auto_mem  = 1;
        lat       = 1;
        out_ready = 1'b1;
        rst       = 1'b0;
        for (int i = 0; i < 40 && n_pops < 4; i++) cyc();
        chk("t1_pops", 64'(n_pops), 64'd4);
        chk("t1_valid_latency", 64'(val_seen - req_seen), 64'd2);

        // Zero-latency acks with stalled consumer: fill to DEPTH and stop requesting
        do_reset();
        n_acks   = 0;
        n_pops   = 0;
        auto_mem = 1;
        lat      = 0;
        repeat (8) cyc();
        chk("t2_acks", 64'(n_acks), 64'd4);
        chk("t2_mem_req_idle", 64'(mem_req), 64'd0);
        chk("t2_full_count", 64'(fifo_count), 64'd4);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        repeat (4) cyc();
        chk("t2_one_more_ack", 64'(n_acks), 64'd5);
        chk("t2_mem_req_idle2", 64'(mem_req), 64'd0);
        chk("t2_full_count2", 64'(fifo_count), 64'd4);

        // Streaming: push and pop every cycle, occupancy steady, pointers wrap
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t6_steady_count", 64'(fifo_count), 64'd3);
        end
        chk("t6_pops", 64'(n_pops), 64'd11);
        chk("t6_acks", 64'(n_acks), 64'd14);

        // Redirect with a request outstanding: DROP keeps the handshake, data discarded
        do_reset();
        out_ready = 1'b1;
        cyc();
        chk("t3_first_req", 64'(mem_req), 64'd1);
        chk("t3_first_addr", mem_addr, 64'h0);
        ack1();
        ack1();
        chk("t3_addr8", mem_addr, 64'h8);
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        cyc();
        redirect = 1'b0;
        chk("t3_flush_valid", 64'(out_valid), 64'd0);
        chk("t3_drop_req", 64'(mem_req), 64'd1);
        cyc();
        cyc();
        chk("t3_drop_addr_held", mem_addr, 64'h8);
        chk("t3_drop_req_held", 64'(mem_req), 64'd1);
        ack1();
        chk("t3_dropped_count", 64'(fifo_count), 64'd0);
        wait_req();
        chk("t3_new_addr", mem_addr, 64'h100);
        pops0 = n_pops;
        ack1();
        cyc();
        chk("t3_new_pop", 64'(n_pops - pops0), 64'd1);

        // Redirect and ack in the same cycle with two entries buffered
        do_reset();
        cyc();
        ack1();
        ack1();
        chk("t4_count2", 64'(fifo_count), 64'd2);
        mem_ack     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        cyc();
        mem_ack  = 1'b0;
        redirect = 1'b0;
        chk("t4_flushed_count", 64'(fifo_count), 64'd0);
        chk("t4_flushed_valid", 64'(out_valid), 64'd0);
        wait_req();
        chk("t4_new_addr", mem_addr, 64'h200);
        pops0     = n_pops;
        out_ready = 1'b1;
        ack1();
        cyc();
        chk("t4_new_pop", 64'(n_pops - pops0), 64'd1);

        // Reset asserted mid-request with three entries buffered
        do_reset();
        cyc();
        ack1();
        ack1();
        ack1();
        chk("t5_count3", 64'(fifo_count), 64'd3);
        chk("t5_req_active", 64'(mem_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_mem_req", 64'(mem_req), 64'd0);
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_count", 64'(fifo_count), 64'd0);
        chk("t5_async_addr", mem_addr, 64'h0);
        cyc();
        sb.delete();
        exp_addr     = '0;
        drop_pending = 0;
        rst          = 1'b0;
        mem_ack      = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("t5_stray_ack_count", 64'(fifo_count), 64'd0);
        chk("t5_restart_req", 64'(mem_req), 64'd1);
        chk("t5_restart_addr", mem_addr, 64'h0);
        pops0     = n_pops;
        out_ready = 1'b1;
        ack1();
        cyc();
        chk("t5_restart_pop", 64'(n_pops - pops0), 64'd1);

        // Redirect from IDLE near the top of the address space: N+1 request, +4 wraps to 0
        do_reset();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc();
        redirect = 1'b0;
        chk("t7_req_next_cycle", 64'(mem_req), 64'd1);
        chk("t7_aligned_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        pops0 = n_pops;
        ack1();
        chk("t7_wrapped_addr", mem_addr, 64'h0);
        ack1();
        cyc();
        cyc();
        chk("t7_pops", 64'(n_pops - pops0), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
